dcache_ctrl: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache controller in the MEM stage.
- Sits between the pipeline's load/store port (EX/MEM outputs) and the off-chip data memory.
- Serves hits in the cycle they are presented.
- On a miss it raises a stall to the pipeline, writes back any dirty victim, refills the line, then completes the access.

---
 rtl/dcache_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back write-allocate data cache controller
//
// Purpose: serves pipeline loads/stores from a direct-mapped cache. Hits complete
// in the cycle they are presented. A miss stalls the pipeline, writes back a dirty
// victim, refills the line, and then lets the held request hit.
//
// Optional feature: define DCACHE_STATS_EN to add the hit/miss counter outputs.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   p1_req_i / p1_we_i            pipeline access request, 1 = store
//   p1_addr_i / p1_wdata_i        byte address (bits [1:0] ignored), store data
//   p1_rdata_o                    load data (valid on a load hit with no stall)
//   p1_stall_o                    pipeline hold
//   mem_req_o / mem_we_o          memory request, 1 = write-back, 0 = refill
//   mem_addr_o                    line-aligned memory address
//   mem_wdata_o / mem_rdata_i     victim line out / refill line in (word0 in [31:0])
//   mem_ack_i                     one-cycle transaction-complete pulse
//   stat_hit_o / stat_miss_o      hit and miss counters (DCACHE_STATS_EN only)
module dcache_ctrl #(
    parameter int LINES       = 32,
    parameter int BLOCK_BYTES = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         p1_req_i,
    input  logic         p1_we_i,
    input  logic [31:0]  p1_addr_i,
    input  logic [31:0]  p1_wdata_i,
    output logic [31:0]  p1_rdata_o,
    output logic         p1_stall_o,
    output logic         mem_req_o,
    output logic         mem_we_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_wdata_o,
    input  logic [255:0] mem_rdata_i,
    input  logic         mem_ack_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]  stat_hit_o,
    output logic [31:0]  stat_miss_o
`endif
);

    localparam int OFF_W = $clog2(BLOCK_BYTES);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 32 - OFF_W - IDX_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WB    = 2'd1;
    localparam logic [1:0] S_ALLOC = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [LINES-1:0] valid_q, valid_d;
    logic [LINES-1:0] dirty_q, dirty_d;
    logic [255:0]     data_q [LINES];
    logic [TAG_W-1:0] tag_q  [LINES];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] req_tag;
    logic [2:0]       word_sel;
    logic [255:0]     cur_line;
    logic [TAG_W-1:0] cur_tag;
    logic             hit;

    // Array write port: one line and/or tag write per cycle, always at idx.
    logic             line_we;
    logic [255:0]     line_d;
    logic             tag_we;

    logic             unused_addr_lsb;
    assign unused_addr_lsb = ^p1_addr_i[1:0];

    assign idx      = p1_addr_i[OFF_W+IDX_W-1:OFF_W];
    assign req_tag  = p1_addr_i[31:OFF_W+IDX_W];
    assign word_sel = p1_addr_i[OFF_W-1:2];
    assign cur_line = data_q[idx];
    assign cur_tag  = tag_q[idx];
    assign hit      = p1_req_i & valid_q[idx] & (cur_tag == req_tag);

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        line_we     = 1'b0;
        line_d      = cur_line;
        tag_we      = 1'b0;
        p1_stall_o  = 1'b0;
        p1_rdata_o  = 32'h0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = 32'h0;
        mem_wdata_o = '0;

        case (state_q)
            S_IDLE: begin
                if (hit) begin
                    if (p1_we_i) begin
                        line_we                      = 1'b1;
                        line_d[{word_sel, 5'b0} +: 32] = p1_wdata_i;
                        dirty_d[idx]                 = 1'b1;
                    end else begin
                        p1_rdata_o = cur_line[{word_sel, 5'b0} +: 32];
                    end
                end else if (p1_req_i) begin
                    p1_stall_o = 1'b1;
                    state_d    = (valid_q[idx] & dirty_q[idx]) ? S_WB : S_ALLOC;
                end
            end
            S_WB: begin
                // Dirty bit stays set until the refill replaces the line.
                p1_stall_o  = 1'b1;
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {cur_tag, idx, {OFF_W{1'b0}}};
                mem_wdata_o = cur_line;
                if (mem_ack_i) begin
                    state_d = S_ALLOC;
                end
            end
            S_ALLOC: begin
                p1_stall_o = 1'b1;
                mem_req_o  = 1'b1;
                mem_addr_o = {req_tag, idx, {OFF_W{1'b0}}};
                if (mem_ack_i) begin
                    // The held request re-evaluates as a hit back in IDLE.
                    line_we      = 1'b1;
                    line_d       = mem_rdata_i;
                    tag_we       = 1'b1;
                    valid_d[idx] = 1'b1;
                    dirty_d[idx] = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Data and tag arrays are not reset; a write coinciding with reset is dropped.
    always_ff @(posedge clk_i) begin
        if (!rst_i && line_we) begin
            data_q[idx] <= line_d;
        end
        if (!rst_i && tag_we) begin
            tag_q[idx] <= req_tag;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] stat_hit_q, stat_hit_d;
    logic [31:0] stat_miss_q, stat_miss_d;

    always_comb begin
        stat_hit_d  = stat_hit_q;
        stat_miss_d = stat_miss_q;
        if (state_q == S_IDLE) begin
            if (hit) begin
                stat_hit_d = stat_hit_q + 32'd1;
            end else if (p1_req_i) begin
                stat_miss_d = stat_miss_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_hit_q  <= 32'h0;
            stat_miss_q <= 32'h0;
        end else begin
            stat_hit_q  <= stat_hit_d;
            stat_miss_q <= stat_miss_d;
        end
    end

    assign stat_hit_o  = stat_hit_q;
    assign stat_miss_o = stat_miss_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - directed self-checking bench for dcache_ctrl
module tb_dcache_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req = 1'b0;
    logic         we = 1'b0;
    logic [31:0]  addr = 32'h0;
    logic [31:0]  wdata = 32'h0;
    logic [31:0]  rdata;
    logic         stall;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata = '0;
    logic         mem_ack = 1'b0;
`ifdef DCACHE_STATS_EN
    logic [31:0]  stat_hit;
    logic [31:0]  stat_miss;
`endif

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .p1_req_i    (req),
        .p1_we_i     (we),
        .p1_addr_i   (addr),
        .p1_wdata_i  (wdata),
        .p1_rdata_o  (rdata),
        .p1_stall_o  (stall),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .mem_ack_i   (mem_ack)
`ifdef DCACHE_STATS_EN
        ,
        .stat_hit_o  (stat_hit),
        .stat_miss_o (stat_miss)
`endif
    );

    function automatic logic [255:0] mk_line(input logic [31:0] base);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) begin
            l[i*32 +: 32] = base + 32'(i);
        end
        return l;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        adv();
        adv();
        rst = 1'b0;
        sample();
        check("rst_stall", stall, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", {31'b0, |mem_wdata}, 0);
        check("rst_rdata", rdata, 0);

        // 1: cold load miss at 0x40, ack after 10 cycles
        adv();
        req = 1'b1; we = 1'b0; addr = 32'h40;
        sample();
        check("t1_stall_same_cycle", stall, 1);
        check("t1_no_req_in_idle", mem_req, 0);
        adv();
        sample();
        check("t1_alloc_req", mem_req, 1);
        check("t1_alloc_we", mem_we, 0);
        check("t1_alloc_addr", mem_addr, 32'h40);
        repeat (9) adv();
        mem_ack = 1'b1; mem_rdata = mk_line(32'h11110000);
        sample();
        check("t1_req_held", mem_req, 1);
        check("t1_stall_held", stall, 1);
        adv();
        mem_ack = 1'b0;
        sample();
        check("t1_stall_drop", stall, 0);
        check("t1_rdata", rdata, 32'h11110000);
        check("t1_req_drop", mem_req, 0);

        // 2: store hit then load hit
        adv();
        we = 1'b1; addr = 32'h44; wdata = 32'hDEADBEEF;
        sample();
        check("t2_store_stall", stall, 0);
        check("t2_store_mem_req", mem_req, 0);
        adv();
        we = 1'b0;
        sample();
        check("t2_load_stall", stall, 0);
        check("t2_load_rdata", rdata, 32'hDEADBEEF);

        // 3: dirty conflict at 0x440
        adv();
        addr = 32'h440;
        sample();
        check("t3_stall", stall, 1);
        adv();
        mem_ack = 1'b1;
        sample();
        check("t3_wb_req", mem_req, 1);
        check("t3_wb_we", mem_we, 1);
        check("t3_wb_addr", mem_addr, 32'h40);
        check("t3_wb_word1", mem_wdata[63:32], 32'hDEADBEEF);
        check("t3_wb_word0", mem_wdata[31:0], 32'h11110000);
        adv();
        mem_ack = 1'b0;
        sample();
        check("t3_alloc_req", mem_req, 1);
        check("t3_alloc_we", mem_we, 0);
        check("t3_alloc_addr", mem_addr, 32'h440);
        adv();
        adv();
        mem_ack = 1'b1; mem_rdata = mk_line(32'h22220000);
        sample();
        adv();
        mem_ack = 1'b0;
        sample();
        check("t3_stall_drop", stall, 0);
        check("t3_rdata", rdata, 32'h22220000);

        // 4: clean conflict at 0x840, immediate ack
        adv();
        addr = 32'h840;
        sample();
        check("t4_stall_c0", stall, 1);
        adv();
        mem_ack = 1'b1; mem_rdata = mk_line(32'h33330000);
        sample();
        check("t4_stall_c1", stall, 1);
        check("t4_alloc_we", mem_we, 0);
        check("t4_alloc_addr", mem_addr, 32'h840);
        adv();
        mem_ack = 1'b0;
        sample();
        check("t4_stall_drop", stall, 0);
        check("t4_rdata", rdata, 32'h33330000);
        adv();
        req = 1'b0;
        sample();
`ifdef DCACHE_STATS_EN
        // hits: 3 refill completions + store 0x44 + load 0x44
        check("t6_stat_miss", stat_miss, 3);
        check("t6_stat_hit", stat_hit, 5);
`endif

        // word select within the line
        adv();
        req = 1'b1; addr = 32'h848;
        sample();
        check("ws_word2", rdata, 32'h33330002);
        adv();
        addr = 32'h85C;
        sample();
        check("ws_word7", rdata, 32'h33330007);

        // 5: reset during write-back
        adv();
        we = 1'b1; addr = 32'h840; wdata = 32'h5555AAAA;
        sample();
        check("t5_store_stall", stall, 0);
        adv();
        we = 1'b0; addr = 32'h40;
        sample();
        check("t5_miss_stall", stall, 1);
        adv();
        sample();
        check("t5_wb_we", mem_we, 1);
        check("t5_wb_addr", mem_addr, 32'h840);
        check("t5_wb_word0", mem_wdata[31:0], 32'h5555AAAA);
        adv();
        rst = 1'b1; req = 1'b0;
        adv();
        rst = 1'b0;
        sample();
        check("t5_rst_mem_req", mem_req, 0);
        check("t5_rst_stall", stall, 0);
        adv();
        req = 1'b1; addr = 32'h40;
        sample();
        check("t5_reload_stall", stall, 1);
        adv();
        mem_ack = 1'b1; mem_rdata = mk_line(32'h44440000);
        sample();
        check("t5_no_wb", mem_we, 0);
        check("t5_alloc_addr", mem_addr, 32'h40);
        adv();
        mem_ack = 1'b0;
        sample();
        check("t5_stall_drop", stall, 0);
        check("t5_rdata", rdata, 32'h44440000);
        adv();
        req = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
